// File: rtl/logic_tile_px.sv
`default_nettype none
// ============================================================================
//  Module   : logic_tile_px
//  Purpose  : Configurable logic tile of NUM_LE K-input LUT elements with a
//             double-buffered serial configuration chain and bus output muxes.
//  Revision : 1.0
// ============================================================================
module logic_tile_px #(
    parameter int NUM_LE    = 4,
    parameter int K         = 4,
    parameter int BUS_WIDTH = 16,
    parameter int CFG_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 config_en,
    input  logic [CFG_WIDTH-1:0] config_data_in,
    input  logic                 config_commit,
    input  logic                 le_en,
    input  logic [BUS_WIDTH-1:0] bus_in,
    output logic [BUS_WIDTH-1:0] bus_out,
    output logic [NUM_LE-1:0]    le_out,
    output logic [CFG_WIDTH-1:0] config_data_out,
    output logic                 config_done,
    output logic                 config_err
);

    localparam int SEL_W     = $clog2(BUS_WIDTH);
    localparam int OSEL_W    = $clog2(NUM_LE + 1);
    localparam int LUT_BITS  = 2 ** K;
    localparam int LE_BITS   = K * SEL_W + LUT_BITS + 1;
    localparam int CFG_BITS  = NUM_LE * LE_BITS + BUS_WIDTH * OSEL_W;
    localparam int FRAME_LEN = (CFG_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int SH_BITS   = FRAME_LEN * CFG_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_UNCONF   = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SH_BITS-1:0]   shadow_q, shadow_d;
    logic [CFG_BITS-1:0]  active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LE-1:0]    ff_q, ff_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [SH_BITS-1:0]   shadow_shifted;
    logic [NUM_LE-1:0]    comb_v;
    logic                 shift;
    logic                 commit_req;
    logic                 good_commit;

    generate
        if (FRAME_LEN > 1) begin : g_shift_multi
            assign shadow_shifted = {shadow_q[SH_BITS-CFG_WIDTH-1:0], config_data_in};
        end else begin : g_shift_single
            assign shadow_shifted = config_data_in;
        end
    endgenerate

    assign shift       = en & config_en;
    assign commit_req  = en & config_commit;
    assign good_commit = commit_req & ~config_en & (cnt_q == CNT_FULL) &
                         (state_q == ST_SHIFTING);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        ff_d     = ff_q;

        if (shift) begin
            shadow_d = shadow_shifted;
            cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end

        if (good_commit) begin
            active_d = shadow_q[CFG_BITS-1:0];
            done_d   = 1'b1;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = ST_ACTIVE;
        end else if (commit_req) begin
            // A rejected commit restarts the count; a same-cycle shift is the first word.
            err_d   = 1'b1;
            cnt_d   = shift ? CNT_W'(1) : '0;
            state_d = done_q ? ST_ACTIVE : ST_UNCONF;
        end else if (shift) begin
            state_d = ST_SHIFTING;
        end

        if (good_commit) begin
            ff_d = '0;
        end else if (le_en) begin
            ff_d = comb_v;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_UNCONF;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            ff_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ff_q     <= ff_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    generate
        for (genvar j = 0; j < NUM_LE; j++) begin : g_le
            localparam int BASE = j * LE_BITS;
            logic [K-1:0]        idx;
            logic [LUT_BITS-1:0] lut;

            assign lut = active_q[BASE + K*SEL_W +: LUT_BITS];

            for (genvar k = 0; k < K; k++) begin : g_in
                logic [SEL_W-1:0] sel;
                assign sel    = active_q[BASE + k*SEL_W +: SEL_W];
                assign idx[k] = (int'(sel) < BUS_WIDTH) ? bus_in[sel] : 1'b0;
            end

            assign comb_v[j] = lut[idx];
            assign le_out[j] = active_q[BASE + LE_BITS - 1] ? ff_q[j] : comb_v[j];
        end

        for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bus
            logic [OSEL_W-1:0] osel;
            logic              out_b;

            assign osel = active_q[NUM_LE*LE_BITS + i*OSEL_W +: OSEL_W];

            // Out-of-range selects drive 0; only LE outputs feed the bus, never LE inputs.
            always_comb begin
                out_b = 1'b0;
                if (osel == '0) begin
                    out_b = bus_in[i];
                end else begin
                    for (int n = 0; n < NUM_LE; n++) begin
                        if (int'(osel) == n + 1) begin
                            out_b = le_out[n];
                        end
                    end
                end
            end

            assign bus_out[i] = out_b;
        end
    endgenerate

    assign config_data_out = shadow_q[SH_BITS-1 -: CFG_WIDTH];
    assign config_done     = done_q;
    assign config_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_tile_px.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_tile_px
//  Purpose  : Randomized self-checking bench for logic_tile_px against a
//             field-level behavioural model of the tile.
//  Revision : 1.0
// ============================================================================
module tb_logic_tile_px;

    localparam int NLE  = 4;
    localparam int KK   = 4;
    localparam int BW   = 16;
    localparam int SELW = 4;
    localparam int OSW  = 3;
    localparam int LEB  = KK * SELW + (1 << KK) + 1;
    localparam int CFGB = NLE * LEB + BW * OSW;

    logic        clk = 1'b0;
    logic        nrst, en, config_en, cdi, commit, le_en;
    logic [15:0] bus_in, bus_out;
    logic [3:0]  le_out;
    logic        cdo, done, err;

    logic        en2, cen2, commit2, le_en2;
    logic [3:0]  cdi2, cdo2, le_out2;
    logic [15:0] bus_in2, bus_out2;
    logic        done2, err2;

    always #5 clk = ~clk;

    logic_tile_px dut (
        .clk(clk), .nrst(nrst), .en(en), .config_en(config_en),
        .config_data_in(cdi), .config_commit(commit), .le_en(le_en),
        .bus_in(bus_in), .bus_out(bus_out), .le_out(le_out),
        .config_data_out(cdo), .config_done(done), .config_err(err)
    );

    logic_tile_px #(.CFG_WIDTH(4)) dut_w4 (
        .clk(clk), .nrst(nrst), .en(en2), .config_en(cen2),
        .config_data_in(cdi2), .config_commit(commit2), .le_en(le_en2),
        .bus_in(bus_in2), .bus_out(bus_out2), .le_out(le_out2),
        .config_data_out(cdo2), .config_done(done2), .config_err(err2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Field-level configurations: n_* is the one being built, a_* the active one.
    int          n_sel [NLE][KK];
    logic [15:0] n_lut [NLE];
    bit          n_reg [NLE];
    int          n_osel[BW];
    int          a_sel [NLE][KK];
    logic [15:0] a_lut [NLE];
    bit          a_reg [NLE];
    int          a_osel[BW];
    bit          m_ff  [NLE];
    logic [CFGB-1:0] m_shadow;
    int          m_cnt;
    bit          m_done, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CFGB-1:0] pack();
        logic [CFGB-1:0] f;
        f = '0;
        for (int j = 0; j < NLE; j++) begin
            for (int k = 0; k < KK; k++) f[j*LEB + k*SELW +: SELW] = 4'(n_sel[j][k]);
            f[j*LEB + KK*SELW +: 16] = n_lut[j];
            f[j*LEB + LEB - 1]       = n_reg[j];
        end
        for (int i = 0; i < BW; i++) f[NLE*LEB + i*OSW +: OSW] = 3'(n_osel[i]);
        return f;
    endfunction

    function automatic void decode(input logic [CFGB-1:0] f);
        for (int j = 0; j < NLE; j++) begin
            for (int k = 0; k < KK; k++) a_sel[j][k] = int'(f[j*LEB + k*SELW +: SELW]);
            a_lut[j] = f[j*LEB + KK*SELW +: 16];
            a_reg[j] = f[j*LEB + LEB - 1];
        end
        for (int i = 0; i < BW; i++) a_osel[i] = int'(f[NLE*LEB + i*OSW +: OSW]);
    endfunction

    function automatic logic m_comb(input int j, input logic [15:0] b);
        int idx = 0;
        for (int k = 0; k < KK; k++)
            if (a_sel[j][k] < BW && b[a_sel[j][k]]) idx += (1 << k);
        return a_lut[j][idx];
    endfunction

    function automatic logic m_le(input int j, input logic [15:0] b);
        return a_reg[j] ? m_ff[j] : m_comb(j, b);
    endfunction

    function automatic logic [15:0] m_bus(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < BW; i++) begin
            if (a_osel[i] == 0)        r[i] = b[i];
            else if (a_osel[i] <= NLE) r[i] = m_le(a_osel[i] - 1, b);
            else                       r[i] = 1'b0;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_shadow = '0;
        m_cnt    = 0;
        m_done   = 0;
        m_err    = 0;
        for (int j = 0; j < NLE; j++) m_ff[j] = 0;
        decode('0);
    endfunction

    function automatic void model_edge();
        bit shift, cm, good;
        bit nf[NLE];
        shift = en && config_en;
        cm    = en && commit;
        good  = cm && !config_en && (m_cnt == CFGB);
        for (int j = 0; j < NLE; j++) nf[j] = m_comb(j, bus_in);
        for (int j = 0; j < NLE; j++) begin
            if (good)       m_ff[j] = 0;
            else if (le_en) m_ff[j] = nf[j];
        end
        if (good) begin
            decode(m_shadow);
            m_done = 1;
            m_err  = 0;
            m_cnt  = 0;
        end else if (cm) begin
            m_err = 1;
            m_cnt = shift ? 1 : 0;
        end else if (shift) begin
            m_cnt = (m_cnt < CFGB + 1) ? m_cnt + 1 : CFGB + 1;
        end
        if (shift) m_shadow = {m_shadow[CFGB-2:0], cdi};
    endfunction

    task automatic check_outs(input string ph);
        logic [3:0] el;
        for (int j = 0; j < NLE; j++) el[j] = m_le(j, bus_in);
        chk({ph, ":bus_out"}, 32'(bus_out), 32'(m_bus(bus_in)));
        chk({ph, ":le_out"},  32'(le_out),  32'(el));
        chk({ph, ":done"},    32'(done),    32'(m_done));
        chk({ph, ":err"},     32'(err),     32'(m_err));
        chk({ph, ":cdo"},     32'(cdo),     32'(m_shadow[CFGB-1]));
    endtask

    task automatic cyc(input string ph);
        #1 check_outs(ph);
        @(posedge clk);
        if (nrst) model_edge();
        #1;
    endtask

    task automatic shift_bits(input logic [CFGB-1:0] f, input int from, input int to,
                              input bit rnd, input string ph);
        bit shifted;
        for (int w = from; w < to; w++) begin
            shifted = 0;
            while (!shifted) begin
                config_en = 1;
                commit    = 0;
                cdi       = f[CFGB-1-w];
                if (rnd) begin
                    en     = ($urandom_range(0, 3) != 0);
                    le_en  = 1'($urandom_range(0, 1));
                    bus_in = 16'($urandom);
                end else begin
                    en = 1;
                end
                shifted = en;
                cyc(ph);
            end
        end
        config_en = 0;
    endtask

    task automatic do_commit(input string ph);
        en = 1; config_en = 0; commit = 1;
        cyc(ph);
        commit = 0;
    endtask

    task automatic run_rand(input int n, input string ph);
        for (int c = 0; c < n; c++) begin
            en = 1'($urandom_range(0, 1)); config_en = 0; commit = 0;
            le_en = 1'($urandom_range(0, 1)); bus_in = 16'($urandom);
            cyc(ph);
        end
    endtask

    task automatic clear_n();
        for (int j = 0; j < NLE; j++) begin
            for (int k = 0; k < KK; k++) n_sel[j][k] = 0;
            n_lut[j] = '0;
            n_reg[j] = 0;
        end
        for (int i = 0; i < BW; i++) n_osel[i] = 0;
    endtask

    task automatic directed_n();
        clear_n();
        n_sel[0][0] = 0; n_sel[0][1] = 1; n_sel[0][2] = 15; n_sel[0][3] = 15;
        n_lut[0]  = 16'h0008;
        n_osel[4] = 1;
    endtask

    task automatic rand_n();
        for (int j = 0; j < NLE; j++) begin
            for (int k = 0; k < KK; k++) n_sel[j][k] = $urandom_range(0, 15);
            n_lut[j] = 16'($urandom);
            n_reg[j] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < BW; i++) n_osel[i] = $urandom_range(0, 7);
    endtask

    logic [CFGB-1:0] fr;

    initial begin
        nrst = 0; en = 0; config_en = 0; cdi = 0; commit = 0; le_en = 0;
        bus_in = 16'hA5A5;
        en2 = 0; cen2 = 0; cdi2 = '0; commit2 = 0; le_en2 = 0; bus_in2 = '0;
        model_reset();

        #2;
        chk("rst_bus", 32'(bus_out), 32'h0000A5A5);
        chk("rst_le",  32'(le_out),  32'd0);
        chk("rst_done", 32'(done),   32'd0);
        chk("rst_err",  32'(err),    32'd0);
        cyc("rst");
        cyc("rst");
        nrst = 1;

        // Short frame then commit must be rejected, full frame accepted.
        directed_n();
        fr = pack();
        shift_bits(fr, 0, CFGB - 1, 0, "short");
        do_commit("short_commit");
        chk("short_err",  32'(err),  32'd1);
        chk("short_done", 32'(done), 32'd0);
        bus_in = 16'h0003;
        #1 chk("short_bypass", 32'(bus_out), 32'h00000003);
        shift_bits(fr, 0, CFGB, 0, "load");
        do_commit("load_commit");
        chk("load_err",  32'(err),  32'd0);
        chk("load_done", 32'(done), 32'd1);
        bus_in = 16'h0003;
        #1 chk("cfg_bus3", 32'(bus_out), 32'h00000013);
        bus_in = 16'h0001;
        #1 chk("cfg_bus1", 32'(bus_out), 32'h00000001);

        // Registered LE0: half a frame with random traffic, then finish and commit.
        n_reg[0] = 1;
        fr = pack();
        shift_bits(fr, 0, CFGB / 2, 1, "half");
        bus_in = 16'h0003; le_en = 1;
        shift_bits(fr, CFGB / 2, CFGB, 0, "half2");
        le_en = 0;
        do_commit("reg_commit");
        chk("reg_le0_clr", 32'(le_out[0]), 32'd0);
        le_en = 1;
        cyc("reg_capture");
        chk("reg_le0_set", 32'(le_out[0]), 32'd1);
        le_en = 0; bus_in = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            cyc("reg_hold");
            chk("reg_le0_hold", 32'(le_out[0]), 32'd1);
            chk("reg_bus4",     32'(bus_out[4]), 32'd1);
        end

        // Random configurations, including a commit that collides with a shift
        // and a commit after an over-long frame.
        for (int r = 0; r < 6; r++) begin
            rand_n();
            fr = pack();
            if (r == 4) begin
                shift_bits(fr, CFGB - 1, CFGB, 1, "over");
                shift_bits(fr, 0, CFGB, 1, "over");
                do_commit("over_commit");
                chk("over_err", 32'(err), 32'd1);
            end
            if (r == 2) begin
                en = 1; config_en = 1; commit = 1; cdi = fr[CFGB-1];
                cyc("collide");
                commit = 0; config_en = 0;
                chk("collide_err",  32'(err),  32'd1);
                chk("collide_done", 32'(done), 32'd1);
                shift_bits(fr, 1, CFGB, 1, "rnd");
            end else begin
                shift_bits(fr, 0, CFGB, 1, "rnd");
            end
            do_commit("rnd_commit");
            chk("rnd_err",  32'(err),  32'd0);
            chk("rnd_done", 32'(done), 32'd1);
            run_rand(20, "rnd_run");
        end

        // Asynchronous reset in the middle of a frame.
        rand_n();
        fr = pack();
        shift_bits(fr, 0, 100, 1, "abort");
        nrst = 0;
        #1;
        model_reset();
        chk("abort_bus", 32'(bus_out), 32'(bus_in));
        check_outs("abort_rst");
        cyc("abort_hold");
        cyc("abort_hold");
        nrst = 1;
        shift_bits(fr, 0, CFGB, 1, "reload");
        do_commit("reload_commit");
        chk("reload_done", 32'(done), 32'd1);
        run_rand(10, "reload_run");

        // Four-lane instance: 45 words, readback of the first word, commit.
        en = 0; config_en = 0;
        directed_n();
        n_osel[15] = 5;
        fr = pack();
        for (int w = 0; w < CFGB / 4; w++) begin
            en2 = 1; cen2 = 1; cdi2 = fr[CFGB-1-4*w -: 4];
            @(posedge clk); #1;
        end
        cen2 = 0;
        chk("w4_readback", 32'(cdo2),  32'(fr[CFGB-1 -: 4]));
        chk("w4_pre_done", 32'(done2), 32'd0);
        commit2 = 1;
        @(posedge clk); #1;
        commit2 = 0;
        chk("w4_done", 32'(done2), 32'd1);
        chk("w4_err",  32'(err2),  32'd0);
        bus_in2 = 16'h0003;
        #1 chk("w4_bus3", 32'(bus_out2), 32'h00000013);
        bus_in2 = 16'h0001;
        #1 chk("w4_bus1", 32'(bus_out2), 32'h00000001);
        bus_in2 = 16'h8003;
        #1 chk("w4_bus8003", 32'(bus_out2), 32'h00000003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_tile_px.md
LOGIC_TILE_PX -- requirements
Module: logic_tile_px

Interface
REQ-001 Parameter NUM_LE, default 4: number of logic elements in the tile, range 1..8.
REQ-002 Parameter K, default 4: LUT inputs per LE, range 2..6.
REQ-003 Parameter BUS_WIDTH, default 16: routing bus width.
REQ-004 Parameter CFG_WIDTH, default 1: configuration lanes shifted per cycle.
REQ-005 Derived values (localparam):
- SEL_W = clog2(BUS_WIDTH); OSEL_W = clog2(NUM_LE+1).
- LE_BITS = K*SEL_W + 2^K + 1.
- CFG_BITS = NUM_LE*LE_BITS + BUS_WIDTH*OSEL_W.
- FRAME_LEN = ceil(CFG_BITS/CFG_WIDTH); SH_BITS = FRAME_LEN*CFG_WIDTH.
REQ-006 clk  in  1  single clock for configuration and logic, rising edge.
REQ-007 nrst  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  configuration clock-enable.
REQ-009 config_en  in  1  shift request.
REQ-010 config_data_in  in  CFG_WIDTH  shift-in word.
REQ-011 config_commit  in  1  single-cycle commit request.
REQ-012 le_en  in  1  LE flip-flop enable.
REQ-013 bus_in  in  BUS_WIDTH  routing input.
REQ-014 bus_out  out  BUS_WIDTH  routing output.
REQ-015 le_out  out  NUM_LE  LE outputs.
REQ-016 config_data_out  out  CFG_WIDTH  shadow[SH_BITS-1 -: CFG_WIDTH], for chaining and readback.
REQ-017 config_done  out  1  active configuration valid.
REQ-018 config_err  out  1  sticky commit error.

Function
REQ-019 Config storage is double-buffered: shadow (SH_BITS) and active (CFG_BITS); logic reads only active.
REQ-020 Shift: on a cycle with en&config_en, shadow <= {shadow[SH_BITS-CFG_WIDTH-1:0], config_data_in}, and shift_cnt increments, saturating at FRAME_LEN+1.
REQ-021 Active field map: LE j base b=j*LE_BITS.
- Input select k at [b+k*SEL_W +: SEL_W].
- LUT at [b+K*SEL_W +: 2^K].
- Reg-mode bit at [b+LE_BITS-1].
- Output select for bus bit i at [NUM_LE*LE_BITS + i*OSEL_W +: OSEL_W].
- Padding bits are shadow[SH_BITS-1:CFG_BITS] and are never copied.
REQ-022 Commit: en&config_commit&!config_en with shift_cnt==FRAME_LEN causes, at that edge:
- active <= shadow[CFG_BITS-1:0];
- config_done <= 1, config_err <= 0, shift_cnt <= 0;
- all LE flip-flops <= 0.
REQ-023 Commit with shift_cnt!=FRAME_LEN, or asserted together with config_en: active unchanged, config_err <= 1, shift_cnt <= 0; the shift in that cycle still occurs and is counted from 0, making shift_cnt 1.
REQ-024 State machine:
- UNCONF: reset state, config_done=0.
- SHIFTING: entered on the first shift; stays while shift_cnt>0 without a commit.
- ACTIVE: entered on a good commit, from SHIFTING only.
- ACTIVE -> SHIFTING on a shift; config_done stays 1 and the old active config keeps running.
- A bad commit returns to UNCONF if config_done=0, else to ACTIVE.
REQ-025 LE combinational value: idx bit k = bus_in[sel_k], or 0 if sel_k>=BUS_WIDTH; comb_j = LUT_j[idx].
REQ-026 le_out[j] = reg_j ? ff_j : comb_j; ff_j <= comb_j on edges with le_en=1, otherwise it holds.
REQ-027 bus_out[i] = bus_in[i] if osel_i==0; le_out[osel_i-1] if 1<=osel_i<=NUM_LE; 0 otherwise.
REQ-028 A new configuration takes effect combinationally in the cycle after the commit edge (latency 1); a shift never disturbs bus_out or le_out.
REQ-029 Active configuration is a combinational path from bus_in to bus_out; there is no path from le_out back to LE inputs (loop-free by construction).

Reset
REQ-030 nrst=0 asynchronously clears shadow, active, shift_cnt, all ff_j, config_done and config_err, and enters UNCONF; this aborts any shift in progress.
REQ-031 While in reset and after reset: bus_out=bus_in, le_out=0, config_data_out=0.

Verification
REQ-032 Reset, bus_in=16'hA5A5 -> bus_out=16'hA5A5, le_out=0, config_done=0, config_err=0.
REQ-033 Defaults (FRAME_LEN=180). Load: LE0 sel={15,15,1,0}, LUT=16'h0008, osel_4=1, rest 0; 180 shifts then commit. Response: config_done=1; bus_in=16'h0003 -> bus_out=16'h0013; bus_in=16'h0001 -> bus_out=16'h0001.
REQ-034 Commit after 179 shifts -> config_err=1, config_done=0, bus_out=bus_in. A subsequent 180-shift load plus commit -> config_err=0, config_done=1.
REQ-035 In ACTIVE, shift 90 words -> bus_out unchanged throughout. Then set LE0 reg bit in a new frame and commit. Response: le_out[0]=0 until the first le_en edge with bus_in=3, then 1; holds 1 while le_en=0 and bus_in=0.
REQ-036 Assert nrst mid-frame at shift 100 -> outputs immediately match REQ-031. After release, a fresh 180-shift load and commit succeeds.
REQ-037 CFG_WIDTH=4 instance: 45 shifts then commit -> config_done=1. config_data_out shows the first-loaded word after 45 shifts (readback).
